// File: rtl/code_lock_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : code_lock_ctrl_if                                                |
// | Brief    : Keypad strobe input and event-byte valid/ready output bundle.    |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
interface code_lock_ctrl_if #(
  parameter int unsigned DIGIT_W = 4
) ();
  logic               key_valid;
  logic [DIGIT_W-1:0] key_code;
  logic               evt_valid;
  logic [7:0]         evt_byte;
  logic               evt_ready;
  logic               evt_overflow;

  // master: keypad scanner plus UART byte consumer; slave: the lock controller
  modport master (
    output key_valid, key_code, evt_ready,
    input  evt_valid, evt_byte, evt_overflow
  );

  modport slave (
    input  key_valid, key_code, evt_ready,
    output evt_valid, evt_byte, evt_overflow
  );
endinterface
`default_nettype wire

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : code_lock_ctrl                                                   |
// | Brief    : Keypad code lock: compare, programmable code, retry lockout,     |
// |            entry timeout and a valid/ready event FIFO.                      |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module code_lock_ctrl #(
  parameter int unsigned                  CODE_LEN      = 4,
  parameter int unsigned                  DIGIT_W       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE  = 16'h1234,
  parameter int unsigned                  MAX_TRIES     = 3,
  parameter int unsigned                  ENTRY_TIMEOUT = 36000000,
  parameter int unsigned                  UNLOCK_TIME   = 60000000,
  parameter int unsigned                  LOCKOUT_TIME  = 120000000,
  parameter logic [DIGIT_W-1:0]           PROG_KEY      = 4'hA,
  parameter logic [DIGIT_W-1:0]           CLEAR_KEY     = 4'hB,
  parameter int unsigned                  EVT_DEPTH     = 4
) (
  input  logic                              hwclk,
  input  logic                              rst_n,
  code_lock_ctrl_if.slave                   bus,
  output logic                              unlocked,
  output logic                              locked_out,
  output logic                              prog_mode,
  output logic [$clog2(CODE_LEN+1)-1:0]     entry_count,
  output logic [3:0]                        fail_count
);

  localparam int unsigned CODE_W = CODE_LEN * DIGIT_W;
  localparam int unsigned CNT_W  = $clog2(CODE_LEN + 1);
  localparam int unsigned PTR_W  = $clog2(EVT_DEPTH);     // EVT_DEPTH >= 2
  localparam int unsigned LVL_W  = $clog2(EVT_DEPTH + 1);

  localparam logic [CNT_W-1:0] c_last_idx   = CNT_W'(CODE_LEN - 1);
  localparam logic [3:0]       c_max_tries  = 4'(MAX_TRIES);
  localparam logic [31:0]      c_entry_to   = 32'(ENTRY_TIMEOUT);
  localparam logic [31:0]      c_unlock_to  = 32'(UNLOCK_TIME);
  localparam logic [31:0]      c_lockout_to = 32'(LOCKOUT_TIME);

  localparam logic [3:0] c_ev_fail    = 4'h2;
  localparam logic [3:0] c_ev_open    = 4'h3;
  localparam logic [3:0] c_ev_lockout = 4'h4;
  localparam logic [3:0] c_ev_relock  = 4'h5;
  localparam logic [3:0] c_ev_prog    = 4'h6;
  localparam logic [3:0] c_ev_timeout = 4'h7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             r_state;
  logic [CODE_W-1:0]  r_code;
  logic [CODE_W-1:0]  r_buf;
  logic [CNT_W-1:0]   r_entry_count;
  logic [3:0]         r_fail_count;
  logic [31:0]        r_timer;
  logic               r_unlocked;
  logic               r_locked_out;
  logic               r_prog_mode;

  logic               w_is_digit;
  logic               w_is_prog;
  logic               w_is_clear;
  logic [CODE_W-1:0]  w_digit_ext;
  logic [CODE_W-1:0]  w_buf_shift;
  logic               w_last;
  logic               w_match;
  logic               w_entry_to;
  logic               w_unlock_to;
  logic               w_lockout_to;
  logic [3:0]         w_fail_inc;
  logic [3:0]         w_fail_nxt;
  logic               w_push;
  logic [3:0]         w_evt;

  assign w_is_digit   = bus.key_valid && (bus.key_code <= DIGIT_W'(9));
  assign w_is_prog    = bus.key_valid && (bus.key_code == PROG_KEY);
  assign w_is_clear   = bus.key_valid && (bus.key_code == CLEAR_KEY);
  assign w_digit_ext  = CODE_W'(bus.key_code);
  assign w_buf_shift  = (r_buf << DIGIT_W) | w_digit_ext;
  assign w_last       = (r_entry_count == c_last_idx);
  assign w_match      = (r_buf == r_code);
  assign w_entry_to   = (r_timer >= c_entry_to);
  assign w_unlock_to  = (r_timer >= c_unlock_to);
  assign w_lockout_to = (r_timer >= c_lockout_to);
  assign w_fail_inc   = (r_fail_count == 4'hF) ? 4'hF : r_fail_count + 4'd1;

  // Event decode mirrors the transition priorities of the FSM below: keys beat timeouts.
  always_comb begin
    w_push     = 1'b0;
    w_evt      = 4'h0;
    w_fail_nxt = r_fail_count;
    case (r_state)
      S_ENTRY: begin
        if (!w_is_digit && !w_is_clear && w_entry_to) begin
          w_push = 1'b1;
          w_evt  = c_ev_timeout;
        end
      end
      S_CHECK: begin
        w_push = 1'b1;
        if (w_match) begin
          w_fail_nxt = 4'h0;
          w_evt      = c_ev_open;
        end else begin
          w_fail_nxt = w_fail_inc;
          w_evt      = (w_fail_inc == c_max_tries) ? c_ev_lockout : c_ev_fail;
        end
      end
      S_OPEN: begin
        if (w_is_clear || (!w_is_prog && w_unlock_to)) begin
          w_push = 1'b1;
          w_evt  = c_ev_relock;
        end
      end
      S_PROG: begin
        if (w_is_digit && w_last) begin
          w_push = 1'b1;
          w_evt  = c_ev_prog;
        end else if (!w_is_digit && !w_is_prog && !w_is_clear && w_entry_to) begin
          w_push = 1'b1;
          w_evt  = c_ev_timeout;
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_code        <= DEFAULT_CODE;
      r_buf         <= '0;
      r_entry_count <= '0;
      r_fail_count  <= 4'h0;
      r_timer       <= '0;
      r_unlocked    <= 1'b0;
      r_locked_out  <= 1'b0;
      r_prog_mode   <= 1'b0;
    end else begin
      r_timer <= (r_timer == '1) ? r_timer : r_timer + 32'd1;
      case (r_state)
        S_IDLE: begin
          if (w_is_digit) begin
            r_buf         <= w_digit_ext;
            r_entry_count <= CNT_W'(1);
            r_timer       <= '0;
            r_state       <= (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (w_is_digit) begin
            r_buf         <= w_buf_shift;
            r_entry_count <= r_entry_count + CNT_W'(1);
            r_timer       <= '0;
            if (w_last) begin
              r_state <= S_CHECK;
            end
          end else if (w_is_clear || w_entry_to) begin
            r_buf         <= '0;
            r_entry_count <= '0;
            r_timer       <= '0;
            r_state       <= S_IDLE;
          end
        end
        S_CHECK: begin
          r_buf         <= '0;
          r_entry_count <= '0;
          r_timer       <= '0;
          r_fail_count  <= w_fail_nxt;
          if (w_match) begin
            r_state    <= S_OPEN;
            r_unlocked <= 1'b1;
          end else if (w_fail_nxt == c_max_tries) begin
            r_state      <= S_LOCKOUT;
            r_locked_out <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OPEN: begin
          if (w_is_clear) begin
            r_state    <= S_IDLE;
            r_unlocked <= 1'b0;
            r_timer    <= '0;
          end else if (w_is_prog) begin
            r_state       <= S_PROG;
            r_unlocked    <= 1'b0;
            r_prog_mode   <= 1'b1;
            r_buf         <= '0;
            r_entry_count <= '0;
            r_timer       <= '0;
          end else if (w_unlock_to) begin
            r_state    <= S_IDLE;
            r_unlocked <= 1'b0;
            r_timer    <= '0;
          end
        end
        S_PROG: begin
          if (w_is_digit) begin
            r_timer <= '0;
            if (w_last) begin
              r_code        <= w_buf_shift;
              r_buf         <= '0;
              r_entry_count <= '0;
              r_prog_mode   <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_buf         <= w_buf_shift;
              r_entry_count <= r_entry_count + CNT_W'(1);
            end
          end else if (w_is_prog || w_is_clear || w_entry_to) begin
            r_buf         <= '0;
            r_entry_count <= '0;
            r_prog_mode   <= 1'b0;
            r_timer       <= '0;
            r_state       <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (w_lockout_to) begin
            r_fail_count <= 4'h0;
            r_locked_out <= 1'b0;
            r_timer      <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_unlocked   <= 1'b0;
          r_locked_out <= 1'b0;
          r_prog_mode  <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked    = r_unlocked;
  assign locked_out  = r_locked_out;
  assign prog_mode   = r_prog_mode;
  assign entry_count = r_entry_count;
  assign fail_count  = r_fail_count;

  logic [7:0]       r_mem [EVT_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_evt_valid;
  logic             r_overflow;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic [LVL_W-1:0] w_level_nxt;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop  = r_evt_valid && bus.evt_ready;
  assign w_full = (r_level == LVL_W'(EVT_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_wr && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_wr && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_evt_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level     <= w_level_nxt;
      r_evt_valid <= (w_level_nxt != '0);
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge hwclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {w_evt, w_fail_nxt};
    end
  end

  assign bus.evt_valid    = r_evt_valid;
  assign bus.evt_byte     = r_evt_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign bus.evt_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_code_lock_ctrl                                                |
// | Brief    : Directed bench for code_lock_ctrl with an event-byte scoreboard. |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_code_lock_ctrl;

  logic       hwclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       unlocked;
  logic       locked_out;
  logic       prog_mode;
  logic [2:0] entry_count;
  logic [3:0] fail_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [8:0] mon_exp;

  code_lock_ctrl_if #(.DIGIT_W(4)) bus ();

  code_lock_ctrl #(
    .ENTRY_TIMEOUT (50),
    .UNLOCK_TIME   (100),
    .LOCKOUT_TIME  (200)
  ) dut (
    .hwclk       (hwclk),
    .rst_n       (rst_n),
    .bus         (bus),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .prog_mode   (prog_mode),
    .entry_count (entry_count),
    .fail_count  (fail_count)
  );

  always #5 hwclk = ~hwclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic press(input logic [3:0] k);
    @(posedge hwclk); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge hwclk); #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge hwclk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unl"},  unlocked,         0);
    check({tag, "_lko"},  locked_out,       0);
    check({tag, "_prg"},  prog_mode,        0);
    check({tag, "_cnt"},  entry_count,      0);
    check({tag, "_fail"}, fail_count,       0);
    check({tag, "_vld"},  bus.evt_valid,    0);
    check({tag, "_ovf"},  bus.evt_overflow, 0);
    check({tag, "_byte"}, bus.evt_byte,     0);
  endtask

  // Scoreboard: every accepted event byte must match the oldest expectation.
  always @(negedge hwclk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() != 0) mon_exp = {1'b0, exp_q.pop_front()};
      else                   mon_exp = 9'h100;
      check("evt_byte", {1'b0, bus.evt_byte}, mon_exp);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish by 500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.evt_ready = 1'b1;
    idle(3);
    check_all_zero("reset");
    @(posedge hwclk); #2 rst_n = 1'b1;
    idle(2);

    // 1: correct code, latency, auto-relock
    exp_q.push_back(8'h30);
    enter4(16'h1234);
    idle(1); check("t1_unl_n1", unlocked, 0);
    idle(1); check("t1_unl_n2", unlocked, 1);
    drain("t1_open_evt");
    exp_q.push_back(8'h50);
    idle(90); check("t1_still_open", unlocked, 1);
    idle(15); check("t1_relocked", unlocked, 0);
    drain("t1_relock_evt");

    // 2: three failures, lockout ignores keys, then expires
    exp_q.push_back(8'h21);
    enter4(16'h1235); idle(3);
    check("t2_fail1", fail_count, 1);
    exp_q.push_back(8'h22);
    enter4(16'h1235); idle(3);
    check("t2_fail2", fail_count, 2);
    exp_q.push_back(8'h43);
    enter4(16'h1235); idle(2);
    check("t2_locked", locked_out, 1);
    check("t2_fail3", fail_count, 3);
    enter4(16'h1234); idle(2);
    check("t2_ign_unl", unlocked, 0);
    check("t2_ign_cnt", entry_count, 0);
    idle(165); check("t2_still_locked", locked_out, 1);
    idle(35);  check("t2_unlocked_out", locked_out, 0);
    check("t2_fail_clr", fail_count, 0);
    drain("t2_evts");

    // 3: reprogram code to 9876
    exp_q.push_back(8'h30);
    enter4(16'h1234); idle(2);
    check("t3_open", unlocked, 1);
    press(4'hA); idle(1);
    check("t3_prog", prog_mode, 1);
    check("t3_prog_unl", unlocked, 0);
    exp_q.push_back(8'h60);
    enter4(16'h9876); idle(1);
    check("t3_prog_done", prog_mode, 0);
    exp_q.push_back(8'h21);
    enter4(16'h1234); idle(2);
    check("t3_old_code", unlocked, 0);
    exp_q.push_back(8'h30);
    enter4(16'h9876); idle(2);
    check("t3_new_code", unlocked, 1);
    exp_q.push_back(8'h50);
    press(4'hB); idle(1);
    check("t3_clear_relock", unlocked, 0);
    drain("t3_evts");

    // 4: entry timeout and clear
    press(4'h1); press(4'h2);
    exp_q.push_back(8'h70);
    idle(45); check("t4_before_to", entry_count, 2);
    idle(10); check("t4_after_to", entry_count, 0);
    check("t4_to_fail", fail_count, 0);
    drain("t4_to_evt");
    press(4'h1); press(4'hB); idle(1);
    check("t4_clear_cnt", entry_count, 0);
    idle(5); check("t4_clear_noevt", bus.evt_valid, 0);

    // 5: back-pressure, overflow, ordered release
    @(posedge hwclk); #1 bus.evt_ready = 1'b0;
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    exp_q.push_back(8'h30); exp_q.push_back(8'h50);
    enter4(16'h1111); idle(3);
    enter4(16'h1111); idle(3);
    enter4(16'h9876); idle(3);
    press(4'hB); idle(2);
    press(4'h1); idle(60);
    check("t5_overflow", bus.evt_overflow, 1);
    check("t5_valid", bus.evt_valid, 1);
    check("t5_head", bus.evt_byte, 8'h21);
    @(posedge hwclk); #1 bus.evt_ready = 1'b1;
    drain("t5_release");
    idle(3);
    check("t5_empty", bus.evt_valid, 0);
    check("t5_ovf_sticky", bus.evt_overflow, 1);

    // 6: asynchronous reset mid-entry and while open
    press(4'h1); press(4'h2); idle(1);
    check("t6_mid_cnt", entry_count, 2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst_entry");
    idle(2);
    @(posedge hwclk); #2 rst_n = 1'b1;
    idle(1);
    exp_q.push_back(8'h30);
    enter4(16'h1234); idle(2);
    check("t6_default_code", unlocked, 1);
    drain("t6_open_evt");
    idle(2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst_open");
    idle(2);
    @(posedge hwclk); #2 rst_n = 1'b1;
    idle(3);
    check("t6_after_rst", unlocked, 0);

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
